// File: rtl/muldiv_pkg.sv
// Shared encodings for the mult/div sequencer: op codes, FSM states and
// default iteration counts of the multicycle units.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4,
    ST_EXC  = 3'd5
  } state_t;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 33;
  localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer that starts the mult or div unit, waits out its fixed iteration
// count and then writes Hi/Lo, flagging divide-by-zero before the divider runs.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       divisor_zero,
  output logic       busy,
  output logic       done,
  output logic       div0,
  output logic       mult_start,
  output logic       div_a_write,
  output logic       div_b_write,
  output logic       div_a_sel,
  output logic       div_b_sel,
  output logic       md_select,
  output logic       hi_write,
  output logic       lo_write
);

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   count;
  logic               run_last;
  logic               is_mult;
  logic               is_divm;

  assign is_mult  = (op_q == OP_MULT);
  assign is_divm  = (op_q == OP_DIVM);
  // Exit is taken on count == N-1, so the counter never needs to reach N.
  assign run_last = is_mult ? (count == CNT_W'(MULT_CYCLES - 1))
                            : (count == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= OP_MULT;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start && op != OP_RSVD)
        op_q <= op;
      if (state == ST_LOAD)
        count <= '0;
      else if (state == ST_RUN)
        count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    div0        = 1'b0;
    mult_start  = 1'b0;
    div_a_write = 1'b0;
    div_b_write = 1'b0;
    div_a_sel   = 1'b0;
    div_b_sel   = 1'b0;
    md_select   = 1'b0;
    hi_write    = 1'b0;
    lo_write    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start)
          state_next = (op == OP_RSVD) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        busy      = 1'b1;
        md_select = is_mult;
        if (is_mult) begin
          mult_start = 1'b1;
          state_next = ST_RUN;
        end else begin
          div_a_write = 1'b1;
          div_b_write = 1'b1;
          div_a_sel   = is_divm;
          div_b_sel   = is_divm;
          state_next  = divisor_zero ? ST_EXC : ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        md_select = is_mult;
        div_a_sel = is_divm;
        div_b_sel = is_divm;
        if (run_last)
          state_next = ST_WB;
      end
      ST_WB: begin
        busy       = 1'b1;
        md_select  = is_mult;
        div_a_sel  = is_divm;
        div_b_sel  = is_divm;
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_EXC: begin
        div0       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: compares the whole output bundle every
// cycle against hand-derived per-cycle expectations for each operation.
module tb_muldiv_seq_ctrl;

  localparam int MC = 32;
  localparam int DC = 33;

  // Bundle bit order: busy done div0 mult_start a_wr b_wr a_sel b_sel md hi lo
  localparam logic [10:0] B_BUSY = 11'b100_0000_0000;
  localparam logic [10:0] B_DONE = 11'b010_0000_0000;
  localparam logic [10:0] B_DIV0 = 11'b001_0000_0000;
  localparam logic [10:0] B_MST  = 11'b000_1000_0000;
  localparam logic [10:0] B_AWR  = 11'b000_0100_0000;
  localparam logic [10:0] B_BWR  = 11'b000_0010_0000;
  localparam logic [10:0] B_ASEL = 11'b000_0001_0000;
  localparam logic [10:0] B_BSEL = 11'b000_0000_1000;
  localparam logic [10:0] B_MD   = 11'b000_0000_0100;
  localparam logic [10:0] B_HI   = 11'b000_0000_0010;
  localparam logic [10:0] B_LO   = 11'b000_0000_0001;

  localparam int K_MULT  = 0;
  localparam int K_DIV   = 1;
  localparam int K_DIVMZ = 2;
  localparam int K_RSVD  = 3;
  localparam int K_DIVM  = 4;
  localparam int K_DIVZ  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       divisor_zero = 1'b0;
  logic       busy, done, div0, mult_start, div_a_write, div_b_write;
  logic       div_a_sel, div_b_sel, md_select, hi_write, lo_write;

  int checks = 0;
  int failures = 0;

  muldiv_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .busy(busy), .done(done), .div0(div0), .mult_start(mult_start),
    .div_a_write(div_a_write), .div_b_write(div_b_write),
    .div_a_sel(div_a_sel), .div_b_sel(div_b_sel), .md_select(md_select),
    .hi_write(hi_write), .lo_write(lo_write)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outVec();
    return {busy, done, div0, mult_start, div_a_write, div_b_write,
            div_a_sel, div_b_sel, md_select, hi_write, lo_write};
  endfunction

  // Expected bundle k cycles after the edge that sampled start (k=1 is LOAD).
  function automatic logic [10:0] expVec(int kind, int k);
    logic [10:0] v;
    v = '0;
    case (kind)
      K_MULT: begin
        if (k == 1)                    v = B_BUSY | B_MST | B_MD;
        else if (k >= 2 && k <= 1+MC)  v = B_BUSY | B_MD;
        else if (k == 2+MC)            v = B_BUSY | B_MD | B_HI | B_LO;
        else if (k == 3+MC)            v = B_DONE;
      end
      K_DIV: begin
        if (k == 1)                    v = B_BUSY | B_AWR | B_BWR;
        else if (k >= 2 && k <= 1+DC)  v = B_BUSY;
        else if (k == 2+DC)            v = B_BUSY | B_HI | B_LO;
        else if (k == 3+DC)            v = B_DONE;
      end
      K_DIVM: begin
        if (k == 1)                    v = B_BUSY | B_AWR | B_BWR | B_ASEL | B_BSEL;
        else if (k >= 2 && k <= 1+DC)  v = B_BUSY | B_ASEL | B_BSEL;
        else if (k == 2+DC)            v = B_BUSY | B_ASEL | B_BSEL | B_HI | B_LO;
        else if (k == 3+DC)            v = B_DONE;
      end
      K_DIVMZ: begin
        if (k == 1)                    v = B_BUSY | B_AWR | B_BWR | B_ASEL | B_BSEL;
        else if (k == 2)               v = B_DIV0;
      end
      K_DIVZ: begin
        if (k == 1)                    v = B_BUSY | B_AWR | B_BWR;
        else if (k == 2)               v = B_DIV0;
      end
      K_RSVD: begin
        if (k == 1)                    v = B_DONE;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int opLen(int kind);
    case (kind)
      K_MULT:               return 4 + MC;
      K_DIV, K_DIVM:        return 4 + DC;
      K_DIVMZ, K_DIVZ:      return 3;
      default:              return 2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %b, expected %b", tag, observed[10:0], expected[10:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, then checks every cycle through one idle cycle after it ends.
  // With midStart, start is re-raised (as a DIV) in every later cycle of the op.
  task automatic applyStimulus(input string tag, input logic [1:0] opCode,
                               input logic dz, input int kind, input bit midStart);
    int len;
    len = opLen(kind);
    start = 1'b1;
    op = opCode;
    divisor_zero = dz;
    tick();
    for (int k = 1; k <= len; k++) begin
      checkOutput($sformatf("%s k=%0d", tag, k), {21'd0, outVec()}, {21'd0, expVec(kind, k)});
      if (k < len) begin
        start = midStart;
        if (midStart) op = 2'b01;
        if (k >= 2) divisor_zero = ~divisor_zero;
        tick();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    $display("[TB] muldiv_seq_ctrl directed test");

    // Reset state, then a MULT aborted by a 2-cycle reset mid-RUN.
    reset = 1'b0;
    tick();
    tick();
    checkOutput("reset idle", {21'd0, outVec()}, 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("after release", {21'd0, outVec()}, 32'd0);

    start = 1'b1;
    op = 2'b00;
    tick();
    start = 1'b0;
    checkOutput("abort load", {21'd0, outVec()}, {21'd0, expVec(K_MULT, 1)});
    for (int k = 2; k <= 10; k++) tick();
    checkOutput("abort run", {21'd0, outVec()}, {21'd0, expVec(K_MULT, 10)});
    reset = 1'b0;
    tick();
    checkOutput("abort rst1", {21'd0, outVec()}, 32'd0);
    tick();
    checkOutput("abort rst2", {21'd0, outVec()}, 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checkOutput($sformatf("abort idle %0d", k), {21'd0, outVec()}, 32'd0);
    end

    applyStimulus("mult",   2'b00, 1'b0, K_MULT,  1'b0);
    applyStimulus("div",    2'b01, 1'b0, K_DIV,   1'b0);
    applyStimulus("divm0",  2'b10, 1'b1, K_DIVMZ, 1'b0);
    applyStimulus("div0",   2'b01, 1'b1, K_DIVZ,  1'b0);
    applyStimulus("divm",   2'b10, 1'b0, K_DIVM,  1'b0);
    applyStimulus("rsvd",   2'b11, 1'b0, K_RSVD,  1'b0);

    // Starts during RUN/WB/DONE are ignored; the next op starts from the idle cycle after done.
    applyStimulus("multbusy", 2'b00, 1'b0, K_MULT, 1'b1);
    applyStimulus("b2b div",  2'b01, 1'b0, K_DIV,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
